// File: rtl/board_memory.sv
`default_nettype none
// ============================================================================
// board_memory : 10x20 playfield store with pixel colour lookup, occupancy
//                queries and a row-at-a-time line-clear engine.
// Revision     : 1.0
// ============================================================================
module board_memory #(
   parameter int BOARD_X0 = 220,
   parameter int BOARD_Y0 = 40,
   parameter int CELL     = 20,
   parameter int COLS     = 10,
   parameter int ROWS     = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [8:0]  row,
   input  logic [9:0]  column,
   input  logic        lock,
   input  logic [2:0]  lock_block,
   input  logic [3:0]  lk0_x,
   input  logic [3:0]  lk1_x,
   input  logic [3:0]  lk2_x,
   input  logic [3:0]  lk3_x,
   input  logic [4:0]  lk0_y,
   input  logic [4:0]  lk1_y,
   input  logic [4:0]  lk2_y,
   input  logic [4:0]  lk3_y,
   input  logic [3:0]  qx,
   input  logic [4:0]  qy,
   output logic        q_occupied,
   input  logic        clr_board,
   input  logic        clear_start,
   output logic        clear_busy,
   output logic        clear_done,
   output logic [2:0]  lines_cleared,
   output logic [23:0] ram_color
);

   localparam logic [3:0] c_cols     = 4'(COLS);
   localparam logic [4:0] c_rows     = 5'(ROWS);
   localparam logic [4:0] c_last_row = 5'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                          r_state;
   logic [4:0]                      r_y;
   logic [ROWS-1:0][COLS-1:0][2:0]  r_board;
   logic                            r_busy;
   logic                            r_done;
   logic [2:0]                      r_lines;

   logic [3:0][3:0]                 w_lk_x;
   logic [3:0][4:0]                 w_lk_y;
   logic                            w_row_full;
   logic [31:0]                     w_col32;
   logic [31:0]                     w_row32;
   logic                            w_in_board;
   logic [3:0]                      w_cx;
   logic [4:0]                      w_cy;
   logic [2:0]                      w_pix_code;
   logic [23:0]                     w_pix_color;

   assign w_lk_x = {lk3_x, lk2_x, lk1_x, lk0_x};
   assign w_lk_y = {lk3_y, lk2_y, lk1_y, lk0_y};

   always_comb begin
      w_row_full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (r_board[r_y][c] == 3'd0) begin
            w_row_full = 1'b0;
         end
      end
   end

   // Pixel-to-cell mapping: count the cell boundaries already passed
   // instead of dividing, so every pixel maps exactly.
   assign w_col32 = {22'd0, column};
   assign w_row32 = {23'd0, row};

   assign w_in_board = (w_col32 >= BOARD_X0) && (w_col32 < BOARD_X0 + COLS * CELL) &&
                       (w_row32 >= BOARD_Y0) && (w_row32 < BOARD_Y0 + ROWS * CELL);

   always_comb begin
      w_cx = 4'd0;
      for (int i = 1; i < COLS; i++) begin
         if (w_col32 >= BOARD_X0 + i * CELL) begin
            w_cx = 4'(i);
         end
      end
   end

   always_comb begin
      w_cy = 5'd0;
      for (int i = 1; i < ROWS; i++) begin
         if (w_row32 >= BOARD_Y0 + i * CELL) begin
            w_cy = 5'(i);
         end
      end
   end

   assign w_pix_code = r_board[w_cy][w_cx];

   always_comb begin
      case (w_pix_code)
         3'd1:    w_pix_color = {8'd102, 8'd178, 8'd255};
         3'd2:    w_pix_color = {8'd255, 8'd51,  8'd153};
         3'd3:    w_pix_color = {8'd127, 8'd0,   8'd255};
         3'd4:    w_pix_color = {8'd255, 8'd255, 8'd102};
         3'd5:    w_pix_color = {8'd102, 8'd255, 8'd102};
         3'd6:    w_pix_color = {8'd153, 8'd0,   8'd153};
         3'd7:    w_pix_color = {8'd153, 8'd255, 8'd204};
         default: w_pix_color = 24'h000000;
      endcase
   end

   assign ram_color = w_in_board ? w_pix_color : 24'h000000;

   // Walls and floor read as occupied so the piece logic needs no bounds test.
   assign q_occupied = (qx >= c_cols) || (qy >= c_rows) || (r_board[qy][qx] != 3'd0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_board <= '0;
         r_state <= ST_IDLE;
         r_y     <= 5'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_lines <= 3'd0;
      end else if (clr_board) begin
         r_board <= '0;
         r_state <= ST_IDLE;
         r_y     <= 5'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_lines <= 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (lock) begin
                  for (int k = 0; k < 4; k++) begin
                     if ((w_lk_x[k] < c_cols) && (w_lk_y[k] < c_rows)) begin
                        r_board[w_lk_y[k]][w_lk_x[k]] <= lock_block;
                     end
                  end
               end
               if (clear_start) begin
                  r_y     <= c_last_row;
                  r_lines <= 3'd0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (w_row_full) begin
                  r_state <= ST_SHIFT;
               end else if (r_y == 5'd0) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_y <= r_y - 5'd1;
               end
            end
            ST_SHIFT: begin
               // y is kept so a row that drops into place is rescanned.
               for (int r = 1; r < ROWS; r++) begin
                  if (5'(r) <= r_y) begin
                     r_board[r] <= r_board[r-1];
                  end
               end
               r_board[0] <= '0;
               r_lines    <= (r_lines == 3'd7) ? 3'd7 : r_lines + 3'd1;
               r_state    <= ST_SCAN;
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign clear_busy    = r_busy;
   assign clear_done    = r_done;
   assign lines_cleared = r_lines;

endmodule
`default_nettype wire
